// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU, debug probe) arbiter onto a single registered memory command
// port, with probe-burst starvation protection and a command timeout.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W          = 30,
    parameter int unsigned MAX_PROBE_BURST = 4,
    parameter int unsigned TIMEOUT         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // CPU master
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_mask_byte,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    // debug-probe master
    input  logic              probe_req,
    input  logic              probe_we,
    input  logic [ADDR_W-1:0] probe_addr,
    input  logic [3:0]        probe_mask_byte,
    input  logic [31:0]       probe_wdata,
    output logic              probe_gnt,
    output logic              probe_rvalid,
    output logic [31:0]       probe_rdata,
    // slave command port
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_mask_byte,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    localparam int unsigned STREAK_W = $clog2(MAX_PROBE_BURST + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_ISSUE_CPU   = 2'd1;
    localparam logic [1:0] S_ISSUE_PROBE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                issuing;
    logic                timeout_hit;
    logic                accept;
    logic                cpu_starved;

    // Handshake decode: acceptance is either slave ready or command abort.
    always_comb begin
        issuing     = (state_q != S_IDLE);
        timeout_hit = issuing && !mem_ready && (tmo_q == TMO_W'(TIMEOUT - 1));
        accept      = issuing && (mem_ready || timeout_hit);
        cpu_gnt     = accept && (state_q == S_ISSUE_CPU);
        probe_gnt   = accept && (state_q == S_ISSUE_PROBE);
        bus_err     = timeout_hit;
        cpu_stall   = cpu_req && !((state_q == S_ISSUE_CPU) && mem_ready);
        cpu_starved = cpu_req && (streak_q == STREAK_W'(MAX_PROBE_BURST));
    end

    // Next-state, timeout counter and probe-streak bookkeeping.
    always_comb begin
        state_d  = state_q;
        tmo_d    = '0;
        streak_d = streak_q;

        case (state_q)
            S_IDLE: begin
                if (probe_req && !cpu_starved) begin
                    state_d = S_ISSUE_PROBE;
                end else if (cpu_req) begin
                    state_d = S_ISSUE_CPU;
                end
            end
            S_ISSUE_CPU, S_ISSUE_PROBE: begin
                if (accept) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!cpu_req || cpu_gnt) begin
            streak_d = '0;
        end else if (probe_gnt && (streak_q != STREAK_W'(MAX_PROBE_BURST))) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    // State, counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            streak_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
        end
    end

    // Command register: latch the owner's fields on issue, idle the strobes on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr      <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_mask_byte <= '0;
            mem_wdata     <= '0;
        end else if ((state_q == S_IDLE) && (state_d == S_ISSUE_PROBE)) begin
            mem_addr      <= probe_addr;
            mem_read      <= !probe_we;
            mem_write     <= probe_we;
            mem_mask_byte <= probe_mask_byte;
            mem_wdata     <= probe_wdata;
        end else if ((state_q == S_IDLE) && (state_d == S_ISSUE_CPU)) begin
            mem_addr      <= cpu_addr;
            mem_read      <= !cpu_we;
            mem_write     <= cpu_we;
            mem_mask_byte <= cpu_mask_byte;
            mem_wdata     <= cpu_wdata;
        end else if (accept) begin
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
        end
    end

    // Read return: capture data of a successfully accepted read, valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid   <= 1'b0;
            cpu_rdata    <= '0;
            probe_rvalid <= 1'b0;
            probe_rdata  <= '0;
        end else begin
            cpu_rvalid   <= cpu_gnt && mem_read && !timeout_hit;
            probe_rvalid <= probe_gnt && mem_read && !timeout_hit;
            if (cpu_gnt && mem_read && !timeout_hit) begin
                cpu_rdata <= mem_rdata;
            end
            if (probe_gnt && mem_read && !timeout_hit) begin
                probe_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed commands push expected
// grant/read-return events; a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;

    localparam int unsigned ADDR_W = 30;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [3:0]        cpu_mask_byte;
    logic [31:0]       cpu_wdata;
    logic              cpu_gnt, cpu_rvalid, cpu_stall;
    logic [31:0]       cpu_rdata;
    logic              probe_req, probe_we;
    logic [ADDR_W-1:0] probe_addr;
    logic [3:0]        probe_mask_byte;
    logic [31:0]       probe_wdata;
    logic              probe_gnt, probe_rvalid;
    logic [31:0]       probe_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read, mem_write;
    logic [3:0]        mem_mask_byte;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              bus_err;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .MAX_PROBE_BURST(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_mask_byte(cpu_mask_byte), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .probe_req(probe_req), .probe_we(probe_we), .probe_addr(probe_addr),
        .probe_mask_byte(probe_mask_byte), .probe_wdata(probe_wdata),
        .probe_gnt(probe_gnt), .probe_rvalid(probe_rvalid), .probe_rdata(probe_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_mask_byte(mem_mask_byte), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // kind: 0 cpu grant, 1 probe grant, 2 cpu read return, 3 probe read return
    typedef struct packed {
        logic [1:0]        kind;
        logic              err;
        logic              rd;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        mask;
        logic [31:0]       wdata;
        logic [31:0]       rdata;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  ready_delay = 0;
    logic [31:0] rd_val = '0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave model: raise mem_ready after ready_delay issue cycles.
    always @(posedge clk) begin : responder
        int cnt;
        #1;
        if (rst_n && (mem_read || mem_write)) begin
            mem_ready = (cnt == ready_delay);
            mem_rdata = rd_val;
            cnt++;
        end else begin
            mem_ready = 1'b0;
            cnt = 0;
        end
    end

    // Monitor: every grant / read-return cycle consumes one expected event.
    always @(negedge clk) begin : monitor
        ev_t obs;
        if (rst_n && (cpu_gnt || probe_gnt || cpu_rvalid || probe_rvalid || bus_err)) begin
            obs = '0;
            obs.err = bus_err;
            if (cpu_gnt || probe_gnt) begin
                obs.kind  = cpu_gnt ? 2'd0 : 2'd1;
                obs.rd    = mem_read;
                obs.we    = mem_write;
                obs.addr  = mem_addr;
                obs.mask  = mem_mask_byte;
                obs.wdata = mem_wdata;
            end else begin
                obs.kind  = cpu_rvalid ? 2'd2 : 2'd3;
                obs.rdata = cpu_rvalid ? cpu_rdata : probe_rdata;
            end
            check("event_onehot", 128'($countones({cpu_gnt, probe_gnt, cpu_rvalid, probe_rvalid})), 128'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got 0x%0h expected none at %0t", obs, $time);
            end else begin
                check("scoreboard_event", 128'(obs), 128'(exp_q.pop_front()));
            end
        end
    end

    function automatic ev_t mk_gnt(input bit is_probe, input bit we, input logic [ADDR_W-1:0] a,
                                   input logic [3:0] m, input logic [31:0] wd, input bit err);
        ev_t e = '0;
        e.kind = is_probe ? 2'd1 : 2'd0;
        e.err = err; e.rd = !we; e.we = we;
        e.addr = a; e.mask = m; e.wdata = wd;
        return e;
    endfunction

    // Issue one command and follow it to its grant; checks issue length, field
    // stability, return timing and the return to idle.
    task automatic do_cmd(input bit is_probe, input bit we, input logic [ADDR_W-1:0] a,
                          input logic [3:0] m, input logic [31:0] wd, input int exp_cycles,
                          input bit err, input logic [31:0] exp_rd);
        ev_t e;
        int cycles = 0;
        int bound = 0;
        bit seen = 0;
        bit stable = 1;
        e = mk_gnt(is_probe, we, a, m, wd, err);
        exp_q.push_back(e);
        if (!we && !err) begin
            e = '0; e.kind = is_probe ? 2'd3 : 2'd2; e.rdata = exp_rd;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        if (is_probe) begin
            probe_req = 1; probe_we = we; probe_addr = a; probe_mask_byte = m; probe_wdata = wd;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_mask_byte = m; cpu_wdata = wd;
        end
        while (!seen && bound < 100) begin
            @(negedge clk);
            bound++;
            if (mem_read || mem_write) begin
                cycles++;
                if (mem_addr !== a || mem_wdata !== wd || mem_mask_byte !== m || mem_write !== we)
                    stable = 0;
                // late changes on the request fields must not reach the bus
                if (is_probe) begin
                    probe_addr = ~a; probe_wdata = ~wd; probe_mask_byte = ~m;
                end else begin
                    cpu_addr = ~a; cpu_wdata = ~wd; cpu_mask_byte = ~m;
                end
            end
            seen = is_probe ? probe_gnt : cpu_gnt;
        end
        check("grant_seen", 128'(seen), 128'd1);
        check("issue_cycles", 128'(cycles), 128'(exp_cycles));
        check("cmd_stable", 128'(stable), 128'd1);
        @(posedge clk); #1;
        if (is_probe) probe_req = 0; else cpu_req = 0;
        @(negedge clk);
        check("rvalid_timing", 128'(is_probe ? probe_rvalid : cpu_rvalid), 128'(!we && !err));
        check("idle_after", 128'({mem_read, mem_write}), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; mem_ready = 0; mem_rdata = '0;
        cpu_req = 1; cpu_we = 0; cpu_addr = '0; cpu_mask_byte = '0; cpu_wdata = '0;
        probe_req = 0; probe_we = 0; probe_addr = '0; probe_mask_byte = '0; probe_wdata = '0;
        #3;
        check("reset_outputs", 128'({cpu_gnt, cpu_rvalid, cpu_rdata, probe_gnt, probe_rvalid,
                                     probe_rdata, mem_read, mem_write, mem_mask_byte, bus_err}), 128'd0);
        check("reset_mem_addr_data", 128'({mem_addr, mem_wdata}), 128'd0);
        check("reset_stall", 128'(cpu_stall), 128'd1);
        cpu_req = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // CPU read, immediate ready
        ready_delay = 0; rd_val = 32'hDEADBEEF;
        do_cmd(0, 0, 30'h40, 4'hF, 32'h0, 1, 0, 32'hDEADBEEF);

        // probe write, ready after 3 wait cycles
        ready_delay = 3;
        do_cmd(1, 1, 30'h100, 4'h1, 32'h41, 4, 0, 32'h0);

        // probe read; CPU read data must be held
        ready_delay = 1; rd_val = 32'h12345678;
        do_cmd(1, 0, 30'h200, 4'hF, 32'h0, 2, 0, 32'h12345678);
        check("cpu_rdata_hold", 128'(cpu_rdata), 128'hDEADBEEF);
        check("probe_rdata_hold", 128'(probe_rdata), 128'h12345678);

        // both masters requesting continuously: P,P,P,P,C twice
        ready_delay = 0;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) exp_q.push_back(mk_gnt(0, 1, 30'h10, 4'h3, 32'hC0C0C0C0, 0));
            else            exp_q.push_back(mk_gnt(1, 1, 30'h20, 4'hC, 32'hB0B0B0B0, 0));
        end
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 30'h10; cpu_mask_byte = 4'h3; cpu_wdata = 32'hC0C0C0C0;
        probe_req = 1; probe_we = 1; probe_addr = 30'h20; probe_mask_byte = 4'hC; probe_wdata = 32'hB0B0B0B0;
        begin
            int gnts = 0;
            int bound = 0;
            while (gnts < 10 && bound < 200) begin
                @(negedge clk);
                bound++;
                check("stall_vs_cpu_gnt", 128'(cpu_stall), 128'(!cpu_gnt));
                if (cpu_gnt || probe_gnt) gnts++;
            end
            check("burst_grant_count", 128'(gnts), 128'd10);
        end
        @(posedge clk); #1;
        cpu_req = 0; probe_req = 0;
        repeat (2) @(negedge clk);

        // slave never ready: abort after 16 issue cycles with bus_err
        ready_delay = 1000;
        do_cmd(0, 0, 30'h55, 4'hF, 32'h0, 16, 1, 32'h0);

        // reset during a probe issue discards the command
        @(posedge clk); #1;
        probe_req = 1; probe_we = 0; probe_addr = 30'h77; probe_mask_byte = 4'hF;
        repeat (4) @(negedge clk);
        check("probe_issuing", 128'(mem_read), 128'd1);
        #2 rst_n = 0;
        #1;
        check("midreset_outputs", 128'({probe_gnt, probe_rvalid, mem_read, mem_write, bus_err,
                                        mem_addr, mem_mask_byte}), 128'd0);
        check("midreset_rdata", 128'({cpu_rdata, probe_rdata, mem_wdata}), 128'd0);
        probe_req = 0;
        @(posedge clk); #1 rst_n = 1;
        repeat (4) @(negedge clk);

        // normal CPU traffic afterwards
        ready_delay = 0;
        do_cmd(0, 1, 30'h7, 4'hC, 32'hCAFEF00D, 1, 0, 32'h0);
        ready_delay = 2; rd_val = 32'hA5A55A5A;
        do_cmd(0, 0, 30'h3FFFFFFF, 4'hF, 32'h0, 3, 0, 32'hA5A55A5A);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 30, word-address width of every address port.
REQ-002 Parameter MAX_PROBE_BURST, default 4, consecutive probe grants allowed while cpu_req is pending.
REQ-003 Parameter TIMEOUT, default 16, cycles an issued command may wait for mem_ready before abort.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cpu_req, cpu_we  in  1 each  CPU request; 1=write, 0=read.
REQ-007 cpu_addr  in  ADDR_W  CPU word address.
REQ-008 cpu_mask_byte  in  4; cpu_wdata  in  32  CPU byte enables, write data.
REQ-009 cpu_gnt, cpu_rvalid  out  1 each  CPU command accepted; CPU read data valid.
REQ-010 cpu_rdata  out  32  CPU read data.
REQ-011 cpu_stall  out  1  CPU request pending and not accepted this cycle.
REQ-012 probe_req, probe_we, probe_addr, probe_mask_byte, probe_wdata  in  1/1/ADDR_W/4/32  debug-probe request, same meaning as CPU.
REQ-013 probe_gnt, probe_rvalid  out  1 each; probe_rdata  out  32  probe handshake and read return.
REQ-014 mem_addr  out  ADDR_W; mem_read, mem_write  out  1 each; mem_mask_byte  out  4; mem_wdata  out  32  registered command to the slave bus mux.
REQ-015 mem_rdata  in  32; mem_ready  in  1  slave accepts command; read data valid on mem_rdata in the same cycle.
REQ-016 bus_err  out  1  one-cycle pulse on command timeout.

Function
REQ-017 FSM states: IDLE, ISSUE_CPU, ISSUE_PROBE.
REQ-018 IDLE: probe_req=1 and not starving CPU -> ISSUE_PROBE; else cpu_req=1 -> ISSUE_CPU; else stay.
REQ-019 Starvation rule: CPU wins over probe when probe_streak==MAX_PROBE_BURST and cpu_req=1.
REQ-020 probe_streak: +1 per accepted probe command while cpu_req=1; cleared on accepted CPU command or any cycle with cpu_req=0; saturates at MAX_PROBE_BURST.
REQ-021 On IDLE->ISSUE_x, owner's addr/we/mask_byte/wdata are latched into mem_* registers; mem_read=!we, mem_write=we.
REQ-022 mem_* held constant throughout ISSUE_x; mem_read=mem_write=0 in IDLE.
REQ-023 Acceptance: ISSUE_x with mem_ready=1 -> owner gnt=1 (combinational, that cycle only), next state IDLE, timeout counter cleared.
REQ-024 Read return: accepted read registers mem_rdata into owner rdata; owner rvalid=1 exactly one cycle after gnt; rdata holds value until next owner read.
REQ-025 Writes produce no rvalid.
REQ-026 Latency: req sampled at edge t -> mem_* valid from t+1 -> earliest gnt in cycle t+1, rvalid in t+2; max throughput one transaction per 2 cycles.
REQ-027 Requester holds req and command fields stable until gnt, drops req the cycle after gnt unless issuing a new command; changes before gnt are ignored (latched copy used).
REQ-028 cpu_stall = cpu_req & ~(state==ISSUE_CPU & mem_ready).
REQ-029 Timeout: counter increments each ISSUE_x cycle with mem_ready=0; reaching TIMEOUT -> bus_err=1, owner gnt=1, no rvalid, next IDLE.
REQ-030 Simultaneous cpu_req and probe_req in IDLE with probe_streak<MAX_PROBE_BURST: probe granted, CPU stalls.
REQ-031 Requests arriving during ISSUE_x wait; no preemption of an issued command.

Reset
REQ-032 rst_n=0 asynchronously forces IDLE; clears probe_streak, timeout counter; sets every output (gnt, rvalid, rdata, mem_*, bus_err) to 0; cpu_stall follows REQ-028.
REQ-033 Reset mid-ISSUE discards the command: no gnt, no rvalid after rst_n rises.
REQ-034 First arbitration is the first rising edge with rst_n=1.

Verification
REQ-035 CPU read addr 0x40, mem_ready=1 immediately, mem_rdata=0xDEADBEEF -> mem_read=1 at t+1, cpu_gnt at t+1, cpu_rvalid=1 and cpu_rdata=0xDEADBEEF at t+2.
REQ-036 Probe write addr 0x100 data 0x41 mask 0x1, mem_ready delayed 3 cycles -> mem_write/mem_addr/mem_wdata stable 4 cycles, probe_gnt only on ready cycle, no probe_rvalid.
REQ-037 cpu_req and probe_req held high continuously -> grant sequence P,P,P,P,C repeating; cpu_stall=0 only on CPU gnt cycles.
REQ-038 mem_ready tied 0 -> bus_err and owner gnt pulse after exactly 16 ISSUE cycles, FSM back to IDLE.
REQ-039 rst_n pulsed low during ISSUE_PROBE -> all outputs 0 immediately, no probe_gnt/probe_rvalid afterwards, next cpu_req served normally.
